// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract that reuses one 4-bit carry-lookahead slice,
// one nibble per clock, LSB first, with a start/done handshake and a synchronous abort.

module cla_4b (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c;
  end
endmodule

module cla_nibble_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf
);
  localparam int unsigned N    = WIDTH / 4;
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic              carry;
  logic              msb_a;
  logic              msb_b;
  logic [IDXW-1:0]   idx;

  logic [3:0]        sum_nib;
  logic              slice_cout;

  cla_4b u_slice (
    .x    (op_a[3:0]),
    .y    (op_b[3:0]),
    .cin  (carry),
    .s    (sum_nib),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      carry  <= 1'b0;
      msb_a  <= 1'b0;
      msb_b  <= 1'b0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      c_out  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // result/c_out/ovf are deliberately left alone so they hold until the first RUN edge
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            msb_a <= a[WIDTH-1];
            msb_b <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            idx   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            idx   <= '0;
          end else begin
            carry  <= slice_cout;
            op_a   <= {4'b0000, op_a[WIDTH-1:4]};
            op_b   <= {4'b0000, op_b[WIDTH-1:4]};
            result <= {sum_nib, result[WIDTH-1:4]};
            if (idx == IDXW'(N - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              idx   <= '0;
              c_out <= slice_cout;
              ovf   <= (msb_a == msb_b) && (sum_nib[3] != msb_a);
            end else begin
              idx <= idx + IDXW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Directed self-checking bench for cla_nibble_sequencer (WIDTH=32): vector table plus
// handshake, abort and reset sequences.

module tb_cla_nibble_sequencer;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        c_out;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;

  cla_nibble_sequencer #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out),
    .ovf    (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] r;
    logic        c;
    logic        o;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Launches one operation from the current cycle (posedge+1) and waits for done.
  // pulse_at/abort_at: edge index (0 = start-sampling edge) before which start/abort is raised.
  task automatic do_op(input logic [31:0] oa, input logic [31:0] ob, input logic os,
                       input int pulse_at, input int abort_at,
                       output logic [31:0] held_r, output logic e0_busy,
                       output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = 0;
    a     = oa;
    b     = ob;
    sub   = os;
    start = 1'b1;
    abort = (abort_at == 0);
    @(posedge clk); #1;
    start   = 1'b0;
    abort   = 1'b0;
    held_r  = result;
    e0_busy = busy;
    if (busy) busy_cnt++;
    for (int k = 1; k <= 16; k++) begin
      if (k == pulse_at) begin
        start = 1'b1;
        a     = $urandom;
        b     = $urandom;
        sub   = ~os;
      end
      abort = (k == abort_at);
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  logic [31:0] held;
  logic        e0b;
  int          lat;
  int          bcnt;
  bit          seen;

  initial begin
    vecs[0] = '{32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[4] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[5] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[8] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    #2;
    check("rst_busy",   32'(busy),  32'd0);
    check("rst_done",   32'(done),  32'd0);
    check("rst_result", result,     32'd0);
    check("rst_c_out",  32'(c_out), 32'd0);
    check("rst_ovf",    32'(ovf),   32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("idle_quiet", 32'(seen), 32'd0);

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, -1, -1, held, e0b, lat, bcnt);
      check($sformatf("v%0d_latency", i), 32'(lat),   32'd8);
      check($sformatf("v%0d_busy",    i), 32'(bcnt),  32'd8);
      check($sformatf("v%0d_result",  i), result,     vecs[i].r);
      check($sformatf("v%0d_c_out",   i), 32'(c_out), 32'(vecs[i].c));
      check($sformatf("v%0d_ovf",     i), 32'(ovf),   32'(vecs[i].o));
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // start pulsed mid-RUN must be ignored
    do_op(32'h0000_000F, 32'h0000_0001, 1'b0, 3, -1, held, e0b, lat, bcnt);
    check("ign_latency", 32'(lat), 32'd8);
    check("ign_result",  result,   32'h0000_0010);
    @(posedge clk); #1;
    check("ign_no_restart", 32'(busy), 32'd0);

    // back-to-back: second start issued in the DONE cycle
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, -1, -1, held, e0b, lat, bcnt);
    check("b2b_first_result", result, 32'h8000_0000);
    do_op(32'h0000_0003, 32'h0000_0005, 1'b1, -1, -1, held, e0b, lat, bcnt);
    check("b2b_held_result", held,     32'h8000_0000);
    check("b2b_e0_busy",     32'(e0b), 32'd1);
    check("b2b_latency",     32'(lat), 32'd8);
    check("b2b_result",      result,   32'hFFFF_FFFE);
    check("b2b_c_out",       32'(c_out), 32'd0);

    // abort together with start in DONE: start wins
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, -1, 0, held, e0b, lat, bcnt);
    check("abort_start_latency", 32'(lat), 32'd8);
    check("abort_start_result",  result,   32'h0000_0000);
    check("abort_start_c_out",   32'(c_out), 32'd1);
    @(posedge clk); #1;

    // abort mid-RUN: no done, back to IDLE
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, 4, held, e0b, lat, bcnt);
    check("abort_no_done", 32'(lat),  32'hFFFF_FFFF);
    check("abort_busy",    32'(bcnt), 32'd4);
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, -1, -1, held, e0b, lat, bcnt);
    check("post_abort_latency", 32'(lat),   32'd8);
    check("post_abort_result",  result,     32'h2345_6789);
    check("post_abort_c_out",   32'(c_out), 32'd0);
    check("post_abort_ovf",     32'(ovf),   32'd0);
    @(posedge clk); #1;

    // asynchronous reset mid-RUN
    a     = 32'h1234_5678;
    b     = 32'h1111_1111;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",   32'(busy),  32'd0);
    check("mid_rst_done",   32'(done),  32'd0);
    check("mid_rst_result", result,     32'd0);
    check("mid_rst_c_out",  32'(c_out), 32'd0);
    check("mid_rst_ovf",    32'(ovf),   32'd0);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("mid_rst_no_done", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cla_nibble_sequencer.md
# cla_nibble_sequencer

Multi-cycle add/subtract sequencer that time-shares one 4-bit carry-lookahead slice (CLA_4B) to produce a WIDTH-bit sum, one nibble per clock, LSB first. It sits beside the ALU as the low-area adder path. It owns operand capture, nibble sequencing, the carry register between nibbles, subtract conditioning, flag generation and the start/done handshake.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of 4; N = WIDTH/4 nibble steps
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE or DONE
- sub  in  1  0 = a+b, 1 = a−b; captured with start
- a  in  WIDTH  operand A; captured with start
- b  in  WIDTH  operand B; captured with start
- abort  in  1  synchronous cancel of an operation in flight
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; result/flags valid
- result  out  WIDTH  sum or difference
- c_out  out  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  out  1  signed two's-complement overflow

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → RUN. Capture opA=a, opB = sub ? ~b : b, carry=sub, msb_a=a[W−1], msb_b=opB[W−1], idx=0.
- RUN, each cycle: the slice adds opA[3:0] + opB[3:0] + carry. At the edge:
  - carry ← slice c_out;
  - opA and opB shift right 4;
  - sum nibble shifts into result from the top (result shifts right 4);
  - idx increments.
- RUN exit: after the step with idx=N−1, go to DONE. At that edge:
  - c_out ← final carry;
  - ovf ← (msb_a == msb_b) && (new result[W−1] != msb_a).
- DONE: done=1 for exactly one cycle. Next state is RUN if start=1 (back-to-back; capture as in IDLE), else IDLE.
- result, c_out and ovf hold from DONE until the next accepted operation's first RUN edge. During RUN, result is intermediate and is not checked.
- start during RUN is ignored; there is no queueing.
- abort=1 in RUN → IDLE at the next edge, no done. result, c_out and ovf are left undefined until the next done. abort has no effect in IDLE or DONE.
- abort and start together in DONE: start wins.
- idx is a ceil(log2 N)-bit counter and never wraps within an operation.

## Timing
- Reset (rst_n=0, immediate, asynchronous):
  - state=IDLE, busy=0, done=0, result=0, c_out=0, ovf=0;
  - internal opA, opB, carry and idx are cleared.
- Reset mid-RUN discards the operation; no done follows.
- Edge E0 samples start=1 and moves to RUN. busy=1 from E0 to E_N.
- Edges E1..E_N process nibbles 0..N−1. E_N enters DONE: busy=0, done=1 in the cycle after E_N.
- Latency: done is high N cycles after the start-sampling edge (8 for WIDTH=32). Throughput is one operation per N+1 cycles back-to-back.
- No combinational path from inputs to outputs. The only combinational path is the 4-bit slice between registers.

## Test plan
- Reset: assert rst_n=0 mid-RUN without a clock edge → all outputs 0 immediately. Release, hold start=0 → state stays IDLE, done never pulses.
- Add 0x0000_000F + 0x0000_0001, sub=0 → done exactly 8 cycles after the start edge, result=0x0000_0010, c_out=0, ovf=0. busy high for exactly 8 cycles.
- Full carry ripple: 0xFFFF_FFFF + 0x0000_0001 → result=0x0000_0000, c_out=1, ovf=0. Then 0x7FFF_FFFF + 0x0000_0001 → result=0x8000_0000, c_out=0, ovf=1.
- Subtract: 0x8000_0000 − 0x0000_0001 → result=0x7FFF_FFFF, c_out=1, ovf=1. Then 0x0000_0003 − 0x0000_0005 → result=0xFFFF_FFFE, c_out=0, ovf=0.
- Handshake:
  - start pulsed at RUN cycle 3 with other operands → ignored; first result unchanged.
  - start held high in DONE → second operation begins at the next edge, its done 8 cycles later, first result held until then.
- Abort: abort=1 at RUN cycle 4 → IDLE next edge, no done pulse. A subsequent 0x1234_5678 + 0x1111_1111 → result=0x2345_6789, c_out=0, ovf=0.
